// File: rtl/keccak_pkg.sv
// Shared constants and FSM state encoding for the Keccak round controller.
package keccak_pkg;

  localparam int LANE_W      = 25;
  localparam int NUM_SLICES  = 64;
  localparam int SLICE_IDX_W = 6;
  localparam int ROUND_IDX_W = 5;
  localparam int FILE_IDX_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PAGE  = 3'd2,
    ST_STATE = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/keccak_idx_delay.sv
// DEPTH-stage shift register carrying {valid, index} from slice read to write-back.
module keccak_idx_delay
  import keccak_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int IDX_W = SLICE_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = in_valid;
    idx_d[0] = in_valid ? in_idx : '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/keccak_round_ctrl.sv
// Keccak-f permutation sequencer: LOAD, then per round 64 slice reads + drain, then rho/pi write.
// Optional KECCAK_CTRL_PERF_EN adds a saturating busy-cycle counter output.
module keccak_round_ctrl
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = 24,
  parameter int DP_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FILE_IDX_W-1:0]  file_index_in,
  output logic                   busy,
  output logic                   done,
  output logic                   load_state,
  output logic [FILE_IDX_W-1:0]  file_index,
  output logic [SLICE_IDX_W-1:0] read_page_line_index,
  output logic                   page_valid,
  output logic                   write_page,
  output logic [SLICE_IDX_W-1:0] write_page_line_index,
  output logic                   write_state,
  output logic [ROUND_IDX_W-1:0] round_idx
`ifdef KECCAK_CTRL_PERF_EN
  , output logic [15:0]          cycle_count
`endif
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_PAGE  = ST_PAGE;
  localparam logic [2:0] S_STATE = ST_STATE;
  localparam logic [2:0] S_DONE  = ST_DONE;

  localparam logic [6:0]             PAGE_LAST  = 7'(NUM_SLICES + DP_LAT - 1);
  localparam logic [ROUND_IDX_W-1:0] ROUND_LAST = ROUND_IDX_W'(NUM_ROUNDS - 1);

  logic [2:0]             state_q, state_d;
  logic [6:0]             page_cnt_q, page_cnt_d;
  logic [ROUND_IDX_W-1:0] round_q, round_d;
  logic [FILE_IDX_W-1:0]  file_q, file_d;

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    file_d     = file_q;
    page_cnt_d = (state_q == S_PAGE && page_cnt_q != PAGE_LAST) ? page_cnt_q + 7'd1 : 7'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          file_d  = file_index_in;
          round_d = '0;
        end
      end
      S_LOAD:  state_d = S_PAGE;
      S_PAGE:  if (page_cnt_q == PAGE_LAST) state_d = S_STATE;
      S_STATE: begin
        if (round_q == ROUND_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PAGE;
          round_d = round_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      page_cnt_q <= '0;
      round_q    <= '0;
      file_q     <= '0;
    end else begin
      state_q    <= state_d;
      page_cnt_q <= page_cnt_d;
      round_q    <= round_d;
      file_q     <= file_d;
    end
  end

  // Counts 64..PAGE_LAST are the datapath drain: no new reads issued.
  assign page_valid           = (state_q == S_PAGE) && !page_cnt_q[6];
  assign read_page_line_index = page_valid ? page_cnt_q[5:0] : '0;
  assign busy                 = (state_q != S_IDLE);
  assign done                 = (state_q == S_DONE);
  assign load_state           = (state_q == S_LOAD);
  assign write_state          = (state_q == S_STATE);
  assign round_idx            = round_q;
  assign file_index           = file_q;

  keccak_idx_delay #(
    .DEPTH (DP_LAT),
    .IDX_W (SLICE_IDX_W)
  ) u_idx_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (page_valid),
    .in_idx    (read_page_line_index),
    .out_valid (write_page),
    .out_idx   (write_page_line_index)
  );

`ifdef KECCAK_CTRL_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  // DONE is excluded so the count reads the same at the done pulse and afterwards.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && start) begin
      cyc_d = '0;
    end else if (state_q != S_IDLE && state_q != S_DONE && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Self-checking bench for keccak_round_ctrl: defaults instance plus a DP_LAT=3 instance.
module tb_keccak_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- DUT A: defaults ----------------
  logic       start_a = 1'b0;
  logic [9:0] fi_a = '0;
  logic       busy_a, done_a, load_a, pv_a, wp_a, ws_a;
  logic [9:0] fidx_a;
  logic [5:0] rd_a, wr_a;
  logic [4:0] rnd_a;
`ifdef KECCAK_CTRL_PERF_EN
  logic [15:0] cc_a;
`endif

  keccak_round_ctrl u_dut_a (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start_a),
    .file_index_in         (fi_a),
    .busy                  (busy_a),
    .done                  (done_a),
    .load_state            (load_a),
    .file_index            (fidx_a),
    .read_page_line_index  (rd_a),
    .page_valid            (pv_a),
    .write_page            (wp_a),
    .write_page_line_index (wr_a),
    .write_state           (ws_a),
    .round_idx             (rnd_a)
`ifdef KECCAK_CTRL_PERF_EN
    , .cycle_count         (cc_a)
`endif
  );

  // ---------------- DUT B: DP_LAT=3, 2 rounds ----------------
  logic       start_b = 1'b0;
  logic [9:0] fi_b = '0;
  logic       busy_b, done_b, load_b, pv_b, wp_b, ws_b;
  logic [9:0] fidx_b;
  logic [5:0] rd_b, wr_b;
  logic [4:0] rnd_b;
`ifdef KECCAK_CTRL_PERF_EN
  logic [15:0] cc_b;
`endif

  keccak_round_ctrl #(.NUM_ROUNDS(2), .DP_LAT(3)) u_dut_b (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start_b),
    .file_index_in         (fi_b),
    .busy                  (busy_b),
    .done                  (done_b),
    .load_state            (load_b),
    .file_index            (fidx_b),
    .read_page_line_index  (rd_b),
    .page_valid            (pv_b),
    .write_page            (wp_b),
    .write_page_line_index (wr_b),
    .write_state           (ws_b),
    .round_idx             (rnd_b)
`ifdef KECCAK_CTRL_PERF_EN
    , .cycle_count         (cc_b)
`endif
  );

  // ---------------- scoreboards ----------------
  typedef struct {
    int         t;
    logic [5:0] idx;
  } wr_exp_t;

  wr_exp_t q_a[$];
  wr_exp_t q_b[$];
  int exp_rd_a = 0, exp_rd_b = 0;
  int wp_cnt_a = 0, ws_cnt_a = 0, done_cnt_a = 0;
  int wp_cnt_b = 0, ws_cnt_b = 0;
  int excl_err = 0;
  int plen_b = 0, last_plen_b = 0;
  bit in_page_b = 0;

  always @(negedge clk) begin
    wr_exp_t e;
    if (rst) begin
      q_a.delete();
      exp_rd_a = 0;
    end else begin
      if (int'(load_a) + int'(wp_a) + int'(ws_a) > 1) excl_err++;
      if (pv_a) begin
        check("rd_idx_a", rd_a, exp_rd_a);
        exp_rd_a = (exp_rd_a + 1) % 64;
        e.t = tick + 1;
        e.idx = rd_a;
        q_a.push_back(e);
      end
      if (wp_a) begin
        wp_cnt_a++;
        if (q_a.size() == 0) check("wr_unexpected_a", 1, 0);
        else begin
          e = q_a.pop_front();
          check("wr_idx_a", wr_a, e.idx);
          check("wr_lat_a", tick, e.t);
        end
      end
      if (ws_a) ws_cnt_a++;
      if (done_a) done_cnt_a++;
    end
  end

  always @(negedge clk) begin
    wr_exp_t e;
    if (rst) begin
      q_b.delete();
      exp_rd_b = 0;
      in_page_b = 0;
    end else begin
      if (int'(load_b) + int'(wp_b) + int'(ws_b) > 1) excl_err++;
      if (pv_b) begin
        check("rd_idx_b", rd_b, exp_rd_b);
        exp_rd_b = (exp_rd_b + 1) % 64;
        e.t = tick + 3;
        e.idx = rd_b;
        q_b.push_back(e);
      end
      if (wp_b) begin
        wp_cnt_b++;
        if (q_b.size() == 0) check("wr_unexpected_b", 1, 0);
        else begin
          e = q_b.pop_front();
          check("wr_idx_b", wr_b, e.idx);
          check("wr_lat_b", tick, e.t);
        end
      end
      if (ws_b) ws_cnt_b++;
      if (pv_b && rd_b == 6'd0 && !in_page_b) begin
        in_page_b = 1;
        plen_b = 1;
      end else if (in_page_b) begin
        if (ws_b) begin
          last_plen_b = plen_b;
          in_page_b = 0;
        end else plen_b++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_a(input logic [9:0] fi, input bit hold);
    int n;
    @(negedge clk);
    start_a = 1'b1;
    fi_a = fi;
    wp_cnt_a = 0;
    ws_cnt_a = 0;
    @(negedge clk);
    if (!hold) start_a = 1'b0;
    n = 1;
    check("load_a", load_a, 1);
    check("fidx_a", fidx_a, fi);
    while (!done_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("latency_a", n, 1586);
    check("ws_count_a", ws_cnt_a, 24);
    check("wp_count_a", wp_cnt_a, 1536);
    check("round_final_a", rnd_a, 23);
`ifdef KECCAK_CTRL_PERF_EN
    check("cc_done_a", cc_a, 1585);
`endif
  endtask

  task automatic check_all_zero_a(input string tag);
    check(tag, {busy_a, done_a, load_a, pv_a, wp_a, ws_a, rnd_a, fidx_a, rd_a, wr_a}, 0);
`ifdef KECCAK_CTRL_PERF_EN
    check({tag, "_cc"}, cc_a, 0);
`endif
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_all_zero_a("reset_a");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy_a", busy_a, 0);

    run_a(10'd7, 1'b0);
    @(negedge clk);
    check("after_done_busy_a", busy_a, 0);
    check("hold_round_a", rnd_a, 23);
    check("hold_fidx_a", fidx_a, 7);
`ifdef KECCAK_CTRL_PERF_EN
    check("cc_hold_a", cc_a, 1585);
`endif

    // start held high across the whole run and through DONE
    run_a(10'd5, 1'b1);
    @(negedge clk);
    check("done_start_ignored_a", busy_a, 0);
    @(negedge clk);
    check("restart_load_a", load_a, 1);
    check("restart_round_a", rnd_a, 0);
`ifdef KECCAK_CTRL_PERF_EN
    check("cc_cleared_a", cc_a, 0);
`endif
    start_a = 1'b0;

    // abort in round 5 at slice 30
    n = 0;
    while (!(rnd_a == 5'd5 && pv_a && rd_a == 6'd30) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_r5s30_a", n < 2000, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero_a("abort_a");
    rst = 1'b0;
    done_cnt_a = 0;
    wp_cnt_a = 0;
    ws_cnt_a = 0;
    repeat (80) @(negedge clk);
    check("abort_no_done_a", done_cnt_a, 0);
    check("abort_no_strobes_a", wp_cnt_a + ws_cnt_a, 0);
    check("abort_idle_a", busy_a, 0);
    run_a(10'd9, 1'b0);

    // DP_LAT=3 instance
    @(negedge clk);
    start_b = 1'b1;
    fi_b = 10'd3;
    wp_cnt_b = 0;
    ws_cnt_b = 0;
    @(negedge clk);
    start_b = 1'b0;
    n = 1;
    check("load_b", load_b, 1);
    while (!done_b && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("latency_b", n, 138);
    check("ws_count_b", ws_cnt_b, 2);
    check("wp_count_b", wp_cnt_b, 128);
    check("page_len_b", last_plen_b, 67);
    check("fidx_b", fidx_b, 3);
    @(negedge clk);
    check("after_done_busy_b", busy_b, 0);

    check("strobe_exclusive", excl_err, 0);
    check("sb_empty_a", q_a.size(), 0);
    check("sb_empty_b", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keccak_round_ctrl.md
KECCAK_ROUND_CTRL -- requirements
Module: keccak_round_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 24: Keccak-f rounds per permutation (1..31).
REQ-002 The block SHALL have parameter DP_LAT, default 1: slice datapath latency in cycles, from read index to write-back (1..4).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic on posedge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request one permutation; sampled only in IDLE.
REQ-006 The block SHALL have port file_index_in, input, 10 bits: input-file number, captured on accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse at completion.
REQ-009 The block SHALL have port load_state, output, 1 bit: state-register file-load strobe.
REQ-010 The block SHALL have port file_index, output, 10 bits: captured file_index_in, held until the next accepted start.
REQ-011 The block SHALL have port read_page_line_index, output, 6 bits: slice read address.
REQ-012 The block SHALL have port page_valid, output, 1 bit: read data at read_page_line_index is live for the datapath.
REQ-013 The block SHALL have port write_page, output, 1 bit: slice write-back strobe.
REQ-014 The block SHALL have port write_page_line_index, output, 6 bits: slice write address.
REQ-015 The block SHALL have port write_state, output, 1 bit: full 1600-bit state write strobe (rho/pi step).
REQ-016 The block SHALL have port round_idx, output, 5 bits: current round, used by the datapath for the iota constant.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, PAGE, STATE and DONE.
REQ-018 In IDLE with start=1, the block SHALL capture file_index_in, clear round_idx and go to LOAD next cycle.
REQ-019 LOAD SHALL last exactly 1 cycle with load_state=1, then go to PAGE.
REQ-020 PAGE SHALL last 64+DP_LAT cycles.
REQ-021 In PAGE cycles 0..63, read_page_line_index SHALL equal the cycle number and page_valid SHALL be 1; in the remaining DP_LAT drain cycles page_valid SHALL be 0.
REQ-022 write_page SHALL assert exactly DP_LAT cycles after each page_valid cycle, with write_page_line_index equal to the read index issued DP_LAT cycles earlier, via a DP_LAT-deep index/valid delay line.
REQ-023 Each round SHALL produce exactly 64 writes, indices 0..63 ascending, with no gaps.
REQ-024 STATE SHALL last exactly 1 cycle with write_state=1.
REQ-025 After STATE, if round_idx==NUM_ROUNDS-1 the block SHALL go to DONE; otherwise it SHALL increment round_idx and return to PAGE.
REQ-026 DONE SHALL last 1 cycle with done=1, then go to IDLE; round_idx SHALL hold its final value until the next start.
REQ-027 Total latency SHALL be 1+NUM_ROUNDS*(65+DP_LAT) cycles of busy after start is accepted, plus 1 DONE cycle (1585+1 at defaults).
REQ-028 load_state, write_page and write_state SHALL be mutually exclusive in every cycle.
REQ-029 start SHALL be ignored while busy=1; start asserted in the DONE cycle SHALL be ignored.
REQ-030 read_page_line_index SHALL be 0 and the strobes SHALL be 0 outside PAGE/LOAD/STATE as applicable.

Reset
REQ-031 rst SHALL take priority over all other inputs.
REQ-032 rst SHALL force state IDLE and clear the delay line.
REQ-033 On reset, busy, done, load_state, page_valid, write_page, write_state, round_idx, file_index, read_page_line_index and write_page_line_index SHALL all be 0.
REQ-034 rst mid-permutation SHALL abort the permutation: no further strobes, no done pulse, and the next start SHALL begin afresh from LOAD.

Configuration
REQ-035 With macro KECCAK_CTRL_PERF_EN defined, the block SHALL add output cycle_count (16 bits): cleared on accepted start, incremented every busy cycle, saturating at 0xFFFF, held after done, cleared by rst.
REQ-036 Without KECCAK_CTRL_PERF_EN, the port and counter SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-037 Package keccak_pkg SHALL hold the FSM state enum, the constants LANE_W=25, NUM_SLICES=64, SLICE_IDX_W=6, ROUND_IDX_W=5 and FILE_IDX_W=10.
REQ-038 The block SHALL contain one sub-module, keccak_idx_delay: a parameterized DP_LAT-stage shift register carrying {valid, index}.

Verification
REQ-039 Defaults, start=1 with file_index_in=7: load_state for 1 cycle with file_index=7; done exactly 1586 cycles after start is sampled; 24 write_state pulses; 1536 write_page pulses.
REQ-040 DP_LAT=3: every write_page_line_index equals the read index 3 cycles earlier; PAGE phase is 67 cycles; no write while page_valid is 0 for more than 3 cycles.
REQ-041 start held high throughout a run: exactly one permutation runs; a second begins only when start is sampled in IDLE after done.
REQ-042 rst asserted in round 5 at slice 30: all outputs are 0 next cycle, with no done pulse; a subsequent start yields a full 1586-cycle run.
REQ-043 Assertion on every cycle: at most one of load_state, write_page and write_state is high.
REQ-044 With KECCAK_CTRL_PERF_EN defined at defaults: cycle_count=1585 at the done pulse and holds; it clears on the next accepted start.
